instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter prog_mem_length, default 8, program-memory address width in bits.
REQ-002 SHALL have parameter prog_mem_width, default 13, instruction word width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pm_addr  output  prog_mem_length  address to program memory, combinational copy of PC.
REQ-006 SHALL have port pm_data  input  prog_mem_width  instruction from program memory (asynchronous read of pm_addr).
REQ-007 SHALL have port instr  output  prog_mem_width  registered instruction presented to decode.
REQ-008 SHALL have port instr_pc  output  prog_mem_length  address from which instr was fetched.
REQ-009 SHALL have port instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-010 SHALL have port decode_ready  input  1  decode accepts instr this cycle.
REQ-011 SHALL have port branch_taken  input  1  redirect fetch to branch_target.
REQ-012 SHALL have port branch_target  input  prog_mem_length  redirect address.
REQ-013 SHALL have port halt_req  input  1  request to stop fetching.
REQ-014 SHALL have port halted  output  1  block is in HALTED state.

Function
REQ-015 SHALL implement states IDLE, RUN, HALTED; IDLE lasts exactly one cycle after reset, then RUN unconditionally.
REQ-016 SHALL define transfer = instr_valid AND decode_ready; slot free = NOT instr_valid OR transfer.
REQ-017 In RUN with slot free and no branch_taken: SHALL load instr<=pm_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
REQ-018 PC increment SHALL be modulo 2^prog_mem_length (max address wraps to 0, no flag).
REQ-019 In RUN with instr_valid=1 and decode_ready=0 (stall): SHALL hold PC, instr, instr_pc, instr_valid unchanged.
REQ-020 branch_taken=1 in RUN SHALL have priority over fetch and stall: PC<=branch_target, instr_valid<=0 next cycle (flush), no fetch that cycle.
REQ-021 Fetch from branch_target SHALL begin the cycle after redirect (one-cycle bubble); instruction at branch_target appears with instr_pc=branch_target.
REQ-022 halt_req=1 in RUN without branch_taken SHALL move to HALTED next cycle; an instruction already valid SHALL remain valid until transferred; no new fetch from that cycle on.
REQ-023 If branch_taken and halt_req coincide in RUN, SHALL apply redirect (PC<=branch_target, flush) and enter HALTED.
REQ-024 HALTED SHALL be left only by rst; branch_taken and halt_req ignored in HALTED; PC frozen; halted=1.
REQ-025 In IDLE SHALL not fetch, instr_valid=0, branch_taken/halt_req ignored.
REQ-026 pm_addr SHALL equal PC in every state, combinationally (zero added latency).
REQ-027 Fetch-to-valid latency SHALL be one cycle: pm_data sampled at edge N appears on instr after edge N.

Reset
REQ-028 rst=1 at a clock edge SHALL set PC=0, instr=0, instr_pc=0, instr_valid=0, halted=0, state=IDLE, overriding all other inputs.
REQ-029 Reset mid-stall or mid-branch SHALL discard the held instruction and pending redirect; first fetch after reset is address 0 on the second cycle after rst deasserts.

Verification
REQ-030 Reset then decode_ready=1, memory word k = k: instr_pc sequence 0,1,2,3 on consecutive cycles, instr equal to instr_pc, first valid on cycle 2 after rst release.
REQ-031 Stall: decode_ready=0 for 3 cycles while instr_pc=5 valid -> instr_pc stays 5, pm_addr stays 6; on release next instr_pc=6.
REQ-032 Wrap: branch to 254, decode_ready=1 -> instr_pc 254, 255, 0, 1.
REQ-033 Branch at instr_pc=10 with branch_target=40 -> one cycle instr_valid=0, then instr_pc=40.
REQ-034 halt_req with instr_pc=7 valid and decode_ready=0 -> halted=1 next cycle, instr_pc=7 held until decode_ready=1, then instr_valid=0, pm_addr stays 8; later branch_taken ignored.
REQ-035 rst asserted during stall at instr_pc=20 -> all outputs zero next cycle, fetch restarts at 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: program-memory port, decode hand-off and redirect/halt controls.
// The slave modport is the fetch unit; the master modport is the surrounding core/environment.
interface instruction_fetch_if #(
  parameter int prog_mem_length = 8,
  parameter int prog_mem_width  = 13
);
  logic [prog_mem_length-1:0] pm_addr;
  logic [prog_mem_width-1:0]  pm_data;
  logic [prog_mem_width-1:0]  instr;
  logic [prog_mem_length-1:0] instr_pc;
  logic                       instr_valid;
  logic                       decode_ready;
  logic                       branch_taken;
  logic [prog_mem_length-1:0] branch_target;
  logic                       halt_req;
  logic                       halted;

  modport slave (
    output pm_addr, instr, instr_pc, instr_valid, halted,
    input  pm_data, decode_ready, branch_taken, branch_target, halt_req
  );

  modport master (
    input  pm_addr, instr, instr_pc, instr_valid, halted,
    output pm_data, decode_ready, branch_taken, branch_target, halt_req
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-slot instruction fetch stage: sequential PC, decode back-pressure, branch redirect
// with a one-cycle bubble, and a sticky halt that only reset clears.
//
//   state   | meaning
//   IDLE    | one settling cycle after reset, no fetch
//   RUN     | fetching whenever the output slot is free
//   HALTED  | no further fetches, PC frozen, held instruction may still drain
module instruction_fetch #(
  parameter int prog_mem_length = 8,
  parameter int prog_mem_width  = 13
) (
  input  logic              clk,
  input  logic              rst,
  instruction_fetch_if.slave fetch_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [prog_mem_length-1:0] pc_q, pc_d;
  logic [prog_mem_width-1:0]  instr_q, instr_d;
  logic [prog_mem_length-1:0] instr_pc_q, instr_pc_d;
  logic                       valid_q, valid_d;
  logic                       halted_q, halted_d;

  logic transfer;
  logic slot_free;

  assign transfer  = valid_q & fetch_if.decode_ready;
  assign slot_free = ~valid_q | transfer;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (fetch_if.branch_taken) begin
          // Redirect wins over fetch and stall; the slot is flushed either way.
          pc_d    = fetch_if.branch_target;
          valid_d = 1'b0;
          if (fetch_if.halt_req) begin
            state_d = S_HALTED;
          end
        end else if (fetch_if.halt_req) begin
          state_d = S_HALTED;
          if (transfer) begin
            valid_d = 1'b0;
          end
        end else if (slot_free) begin
          instr_d    = fetch_if.pm_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + prog_mem_length'(1);
        end
      end
      S_HALTED: begin
        if (transfer) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign fetch_if.pm_addr     = pc_q;
  assign fetch_if.instr       = instr_q;
  assign fetch_if.instr_pc    = instr_pc_q;
  assign fetch_if.instr_valid = valid_q;
  assign fetch_if.halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a cycle-level reference model.
module tb_instruction_fetch;
  localparam int L = 8;
  localparam int W = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if #(.prog_mem_length(L), .prog_mem_width(W)) ifc ();

  instruction_fetch #(.prog_mem_length(L), .prog_mem_width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (ifc)
  );

  logic [W-1:0] mem [256];
  assign ifc.pm_data = mem[ifc.pm_addr];

  int tests = 0;
  int fails = 0;

  // Reference model state
  int        m_pc, m_ipc;
  logic [W-1:0] m_instr;
  bit        m_valid, m_halted, m_started;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("valid",   32'(ifc.instr_valid), 32'(m_valid));
    chk("halted",  32'(ifc.halted),      32'(m_halted));
    chk("pm_addr", 32'(ifc.pm_addr),     32'(m_pc));
    chk("instr_pc",32'(ifc.instr_pc),    32'(m_ipc));
    chk("instr",   32'(ifc.instr),       32'(m_instr));
  endtask

  task automatic cycle(input bit r, input bit dr, input bit bt, input int tgt, input bit hr);
    bit xfer;
    rst               = r;
    ifc.decode_ready  = dr;
    ifc.branch_taken  = bt;
    ifc.branch_target = L'(tgt);
    ifc.halt_req      = hr;
    if (r) begin
      m_pc = 0; m_ipc = 0; m_instr = '0; m_valid = 0; m_halted = 0; m_started = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (!m_halted) begin
      xfer = m_valid && dr;
      if (bt) begin
        m_pc = tgt % 256; m_valid = 0;
        if (hr) m_halted = 1;
      end else if (hr) begin
        m_halted = 1;
        if (xfer) m_valid = 0;
      end else if (!m_valid || xfer) begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 256;
      end
    end else if (m_valid && dr) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst = 1'b1;
    ifc.decode_ready = 0; ifc.branch_taken = 0; ifc.branch_target = '0; ifc.halt_req = 0;
    for (int k = 0; k < 256; k++) mem[k] = W'(k);
    @(negedge clk);

    // Reset and straight-line fetch: first valid on the second cycle after release
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 99, 1);
    chk("rst_valid", 32'(ifc.instr_valid), 0);
    chk("rst_pm_addr", 32'(ifc.pm_addr), 0);
    cycle(0, 1, 0, 0, 0);
    chk("idle_no_fetch", 32'(ifc.instr_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk("seq_instr_pc", 32'(ifc.instr_pc), 32'(i));
      chk("seq_instr", 32'(ifc.instr), 32'(i));
    end
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("pre_stall_pc", 32'(ifc.instr_pc), 5);

    // Stall holding instr_pc=5
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("stall_instr_pc", 32'(ifc.instr_pc), 5);
      chk("stall_pm_addr", 32'(ifc.pm_addr), 6);
    end
    cycle(0, 1, 0, 0, 0);
    chk("stall_release", 32'(ifc.instr_pc), 6);

    // Branch at instr_pc=10 to 40
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    chk("pre_branch_pc", 32'(ifc.instr_pc), 10);
    cycle(0, 1, 1, 40, 0);
    chk("branch_bubble", 32'(ifc.instr_valid), 0);
    cycle(0, 1, 0, 0, 0);
    chk("branch_target_pc", 32'(ifc.instr_pc), 40);
    chk("branch_target_valid", 32'(ifc.instr_valid), 1);

    // Address wrap
    cycle(0, 1, 1, 254, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk("wrap_instr_pc", 32'(ifc.instr_pc), 32'((254 + i) % 256));
    end

    // Reset during a stall at instr_pc=20
    cycle(0, 1, 1, 20, 0);
    cycle(0, 0, 0, 0, 0);
    chk("rst_stall_pc", 32'(ifc.instr_pc), 20);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 77, 0);
    chk("rst_mid_valid", 32'(ifc.instr_valid), 0);
    chk("rst_mid_instr_pc", 32'(ifc.instr_pc), 0);
    chk("rst_mid_instr", 32'(ifc.instr), 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("restart_pc", 32'(ifc.instr_pc), 0);
    chk("restart_valid", 32'(ifc.instr_valid), 1);

    // Halt while instr_pc=7 stalled
    cycle(0, 1, 1, 7, 0);
    cycle(0, 1, 0, 0, 0);
    chk("halt_pre_pc", 32'(ifc.instr_pc), 7);
    cycle(0, 0, 0, 0, 1);
    chk("halt_flag", 32'(ifc.halted), 1);
    chk("halt_hold_valid", 32'(ifc.instr_valid), 1);
    cycle(0, 0, 0, 0, 0);
    chk("halt_hold_pc", 32'(ifc.instr_pc), 7);
    cycle(0, 1, 0, 0, 0);
    chk("halt_drain", 32'(ifc.instr_valid), 0);
    chk("halt_pm_addr", 32'(ifc.pm_addr), 8);
    cycle(0, 1, 1, 3, 1);
    chk("halt_ignore_branch", 32'(ifc.pm_addr), 8);
    chk("halt_sticky", 32'(ifc.halted), 1);

    // Branch and halt together
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 123, 1);
    chk("bt_halt_addr", 32'(ifc.pm_addr), 123);
    chk("bt_halt_flag", 32'(ifc.halted), 1);

    // Randomized epochs with random memory contents
    for (int k = 0; k < 256; k++) mem[k] = W'($urandom);
    for (int e = 0; e < 8; e++) begin
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 80; i++) begin
        cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
              ($urandom_range(0, 39) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
